// File: rtl/decimal_binary.sv
// decimal_binary: keypad-side decimal-to-binary setpoint entry.
//
// Accumulates up to MAX_INT_DIGITS decimal digits into an 8-bit whole-degree
// value, optionally followed by a point and a single fraction digit (0 or 5)
// that becomes the half-degree flag. Enter commits the value to data/decimal
// with a one-cycle data_valid pulse; the block then spends one cycle in DONE
// with key_ready low. Any malformed entry parks the block in ERR until clear.
module decimal_binary #(
    parameter int MAX_INT_DIGITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic [1:0] key_type,
    output logic       key_ready,
    output logic [7:0] data,
    output logic       decimal,
    output logic       data_valid,
    output logic       error,
    output logic [7:0] entry_value,
    output logic [1:0] entry_digits
);

    typedef enum logic [1:0] {
        KEY_DIGIT = 2'b00,
        KEY_POINT = 2'b01,
        KEY_ENTER = 2'b10,
        KEY_CLEAR = 2'b11
    } key_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INT  = 3'd1,
        S_FRAC = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [1:0] MAX_DIGITS = 2'(MAX_INT_DIGITS);

    state_t     state;
    key_t       key;
    logic       frac;        // half-degree flag of the pending entry
    logic       frac_given;  // a fraction digit has already been entered

    // Digit-path arithmetic, evaluated for the current key every cycle.
    logic       key_accept;
    logic [7:0] acc_base;
    logic [1:0] digits_base;
    logic [9:0] acc_sum;
    logic       digit_legal;
    logic       int_digit_bad;
    logic       frac_digit_bad;

    // Accumulator candidate for a digit key; IDLE starts from an empty entry.
    // NOTE: every always_comb output gets a value on every path (defaults first) so no latch is inferred.
    always_comb begin
        key            = key_t'(key_type);
        key_accept     = key_valid && key_ready;
        acc_base       = (state == S_IDLE) ? 8'd0 : entry_value;
        digits_base    = (state == S_IDLE) ? 2'd0 : entry_digits;
        acc_sum        = ({2'b00, acc_base} << 3) + ({2'b00, acc_base} << 1)
                       + {6'd0, key_digit};
        digit_legal    = (key_digit <= 4'd9);
        int_digit_bad  = !digit_legal || (acc_sum > 10'd255)
                       || (digits_base == MAX_DIGITS);
        frac_digit_bad = frac_given || ((key_digit != 4'd0) && (key_digit != 4'd5));
    end

    // Entry state machine with registered outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            key_ready    <= 1'b1;
            data         <= 8'd0;
            decimal      <= 1'b0;
            data_valid   <= 1'b0;
            error        <= 1'b0;
            entry_value  <= 8'd0;
            entry_digits <= 2'd0;
            frac         <= 1'b0;
            frac_given   <= 1'b0;
        end else begin
            // data_valid is a single-cycle pulse; only a commit raises it.
            data_valid <= 1'b0;

            case (state)
                S_DONE: begin
                    // One blind cycle after a commit, then a fresh entry.
                    state        <= S_IDLE;
                    key_ready    <= 1'b1;
                    entry_value  <= 8'd0;
                    entry_digits <= 2'd0;
                    frac         <= 1'b0;
                    frac_given   <= 1'b0;
                end

                S_IDLE, S_INT, S_FRAC, S_ERR: begin
                    if (key_accept) begin
                        if (key == KEY_CLEAR) begin
                            // Abandon the entry; the committed setpoint is kept.
                            state        <= S_IDLE;
                            error        <= 1'b0;
                            entry_value  <= 8'd0;
                            entry_digits <= 2'd0;
                            frac         <= 1'b0;
                            frac_given   <= 1'b0;
                        end else if (state == S_FRAC) begin
                            case (key)
                                KEY_DIGIT: begin
                                    if (frac_digit_bad) begin
                                        state <= S_ERR;
                                        error <= 1'b1;
                                    end else begin
                                        frac       <= (key_digit == 4'd5);
                                        frac_given <= 1'b1;
                                    end
                                end
                                KEY_ENTER: begin
                                    // frac is zeroed on entry to FRAC, so a bare point commits .0
                                    data       <= entry_value;
                                    decimal    <= frac;
                                    data_valid <= 1'b1;
                                    key_ready  <= 1'b0;
                                    state      <= S_DONE;
                                end
                                default: begin
                                    // A second point is malformed.
                                    state <= S_ERR;
                                    error <= 1'b1;
                                end
                            endcase
                        end else if (state != S_ERR) begin
                            // IDLE or INT: building the integer part.
                            case (key)
                                KEY_DIGIT: begin
                                    if (int_digit_bad) begin
                                        state <= S_ERR;
                                        error <= 1'b1;
                                    end else begin
                                        entry_value  <= acc_sum[7:0];
                                        entry_digits <= digits_base + 2'd1;
                                        state        <= S_INT;
                                    end
                                end
                                KEY_POINT: begin
                                    if (state == S_INT && entry_digits != 2'd0) begin
                                        state      <= S_FRAC;
                                        frac       <= 1'b0;
                                        frac_given <= 1'b0;
                                    end else begin
                                        state <= S_ERR;
                                        error <= 1'b1;
                                    end
                                end
                                KEY_ENTER: begin
                                    if (state == S_INT) begin
                                        data       <= entry_value;
                                        decimal    <= 1'b0;
                                        data_valid <= 1'b1;
                                        key_ready  <= 1'b0;
                                        state      <= S_DONE;
                                    end else begin
                                        state <= S_ERR;
                                        error <= 1'b1;
                                    end
                                end
                                default: begin
                                    // Clear is handled above; nothing to do here.
                                end
                            endcase
                        end
                        // In ERR every non-clear key is accepted and ignored.
                    end
                end

                default: begin
                    // Unreachable encodings recover to a clean idle entry.
                    state        <= S_IDLE;
                    key_ready    <= 1'b1;
                    error        <= 1'b0;
                    entry_value  <= 8'd0;
                    entry_digits <= 2'd0;
                    frac         <= 1'b0;
                    frac_given   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/decimal_binary.md
# decimal_binary

Keypad-side decimal-to-binary entry block for the temperature display path. It accepts one decimal digit per keystroke plus point, enter and clear keys, and accumulates a whole-degree binary value with a half-degree flag. On enter it delivers a validated 8-bit setpoint in the same `data` / `decimal` form that the binary-to-decimal display path consumes. It sits between the keypad debouncer and the setpoint register.

## Interface
- `MAX_INT_DIGITS`, default 3: maximum number of integer digits accepted (1–3).
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `key_valid` input 1: a key event is present this cycle (single-cycle pulse from the debouncer).
- `key_digit` input 4: digit value 0–9; qualified by `key_valid` and `key_type == 2'b00`.
- `key_type` input 2: 00 = digit, 01 = point, 10 = enter, 11 = clear.
- `key_ready` output 1: the block can accept a key this cycle.
- `data` output 8: last committed whole-degree value.
- `decimal` output 1: last committed half-degree flag (1 = .5).
- `data_valid` output 1: one-cycle pulse when `data` / `decimal` are updated.
- `error` output 1: sticky error flag; cleared by clear or reset.
- `entry_value` output 8: live integer accumulator, for echo to the display.
- `entry_digits` output 2: number of integer digits entered so far.

## Operation
- **Reset values.** After reset is high at a rising edge: state = IDLE, `data` = 0, `decimal` = 0, `data_valid` = 0, `error` = 0, `entry_value` = 0, `entry_digits` = 0, `key_ready` = 1.
- **Key acceptance.** A key is accepted when `key_valid && key_ready`. `key_ready` is 0 only in DONE.
- **Reserved digit values.** `key_digit` values 10–15 with `key_type` 00 go to ERR.
- **IDLE / INT** (clearing the accumulator is the IDLE→INT entry action):
  - Digit: `acc = acc*10 + digit`. Compute in 10 bits as `(acc<<3)+(acc<<1)+digit`.
  - If the result is > 255, or `entry_digits == MAX_INT_DIGITS`, go to ERR and leave the accumulator unchanged.
  - Otherwise update `entry_value` and increment `entry_digits`. IDLE goes to INT.
  - Point: in INT with `entry_digits` ≥ 1, go to FRAC. In IDLE, go to ERR.
  - Enter: in INT, commit `data = acc`, `decimal = 0`. In IDLE, go to ERR.
- **FRAC:**
  - Digit 0 sets `frac = 0`; digit 5 sets `frac = 1`. Any other digit goes to ERR.
  - A second fraction digit goes to ERR.
  - Point goes to ERR.
  - Enter commits `data = acc`, `decimal = frac`; if no fraction digit was given, `decimal = 0`.
- **Commit.** Register `data` / `decimal`, pulse `data_valid` for exactly 1 cycle, then enter DONE.
- **DONE.** Holds for one cycle with `key_ready = 0`. It then returns to IDLE with `entry_value` and `entry_digits` cleared.
- **ERR:**
  - `error` = 1 and `key_ready` = 1.
  - All keys except clear are accepted and ignored.
  - `data` / `decimal` keep their last committed values.
- **Clear.** Accepted in any state where `key_ready` = 1. It goes to IDLE, clears the accumulator, `entry_digits`, `frac` and `error`, and does not touch `data` / `decimal`.
- **Key encoding.** Exactly one key type per cycle by encoding. Reset has priority over any key in the same cycle.

## Timing
- Key accepted at edge N:
  - `entry_value` / `entry_digits` reflect it after edge N.
  - The state change is visible in cycle N+1.
- Enter accepted at edge N:
  - `data`, `decimal` and `data_valid` = 1 in cycle N+1.
  - `key_ready` = 0 in cycle N+1 (DONE).
  - IDLE and `key_ready` = 1 in cycle N+2.
- Error detected at edge N: `error` = 1 from cycle N+1 until the cycle after clear or reset.
- Reset mid-entry: the partial entry is discarded and outputs return to their reset values; no `data_valid` pulse is emitted.
- Key presented while `key_ready` = 0: dropped, no state change. The debouncer is responsible for not issuing keys in that cycle.

## Test plan
- Digits 2,5,5 then enter → `data` = 255, `decimal` = 0, one `data_valid` pulse 1 cycle after enter, `key_ready` low for 1 cycle.
- Digits 3,7, point, 5, enter → `data` = 37, `decimal` = 1. Then 4, point, enter → `data` = 4, `decimal` = 0.
- Digits 2,5,6 → `error` = 1 after the third digit, `entry_value` stays 25. Enter is ignored, `data` unchanged. Clear → `error` = 0, `entry_digits` = 0.
- Each of these reaches ERR: four digits (1,0,0,0); point as the first key; fraction digit 3; two fraction digits 0,5; `key_digit` = 12.
- Digits 9,9 then reset asserted the cycle before enter → all outputs at reset values, no `data_valid`. A following entry 4,2, enter gives `data` = 42.
- Enter immediately followed by a digit key in the DONE cycle → digit dropped. The next entry starts from `entry_value` = 0.
